// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and constants for the imem loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam logic [7:0] CMD_LOAD       = 8'h4C;
  localparam int         BYTES_PER_WORD = 4;
  localparam int         WORD_WIDTH     = 8 * BYTES_PER_WORD;
  // Word-aligned byte-address step, shared with the PC adder.
  localparam int         ADDR_INCR      = 4;

  function automatic logic is_busy(input state_t s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA) || (s == ST_FINISH);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs little-endian bytes into words
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_done
);

  localparam int NB_IDX = $clog2(BYTES_PER_WORD);

  logic [NB_IDX-1:0]     idx_q;
  logic [WORD_WIDTH-1:0] shift_q;

  // word includes the byte arriving this cycle, so the top can capture it on the 4th strobe.
  always_comb begin
    word                       = shift_q;
    word[{idx_q, 3'b000} +: 8] = byte_data;
    word_done                  = byte_valid && (idx_q == NB_IDX'(BYTES_PER_WORD - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (clear) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (byte_valid) begin
      idx_q   <= idx_q + NB_IDX'(1);
      shift_q <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART-fed instruction memory loader that holds the CPU while loading
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         IMEM_ADDR_WIDTH = 10,
  parameter int         IMEM_DATA_WIDTH = 32,
  parameter logic [7:0] CMD_LOAD        = imem_loader_pkg::CMD_LOAD,
  parameter int         TIMEOUT_CYCLES  = 1_000_000,
  parameter int         NB_TIMEOUT      = 20
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
  output logic [IMEM_DATA_WIDTH-1:0] o_imem_wdata,
  output logic                       o_imem_wen,
  output logic                       o_cpu_en,
  output logic                       o_cpu_rst,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
);

  localparam logic [16:0]           CAPACITY   = 17'(2 ** (IMEM_ADDR_WIDTH - 2));
  localparam logic [NB_TIMEOUT-1:0] TIMER_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                     state_q, state_d;
  logic [7:0]                 count_lo_q;
  logic [15:0]                remain_q;
  logic [IMEM_ADDR_WIDTH-1:0] addr_q;
  logic [NB_TIMEOUT-1:0]      timer_q;
  logic                       wen_q;
  logic [IMEM_ADDR_WIDTH-1:0] waddr_q;
  logic [IMEM_DATA_WIDTH-1:0] wdata_q;

  logic [15:0]                count_full;
  logic [NB_TIMEOUT-1:0]      timer_inc;
  logic                       timeout;
  logic                       in_data;
  logic [WORD_WIDTH-1:0]      word;
  logic                       word_done;

  assign count_full = {i_rx_data, count_lo_q};
  assign timer_inc  = timer_q + NB_TIMEOUT'(1);
  // An arriving byte always beats an expiring timer.
  assign timeout    = (timer_inc == TIMER_LAST) && !i_rx_valid;
  assign in_data    = (state_q == ST_DATA);

  imem_loader_word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (i_rst),
    .clear      (!in_data),
    .byte_valid (in_data && i_rx_valid),
    .byte_data  (i_rx_data),
    .word       (word),
    .word_done  (word_done)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    o_cpu_en  = (state_q == ST_IDLE);
    o_busy    = is_busy(state_q);
    o_cpu_rst = (state_q == ST_FINISH);
    o_done    = (state_q == ST_FINISH);
    o_err     = (state_q == ST_ERROR);
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid && (i_rx_data == CMD_LOAD)) state_d = ST_CNT_LO;
      end
      ST_CNT_LO: begin
        if (i_rx_valid)   state_d = ST_CNT_HI;
        else if (timeout) state_d = ST_ERROR;
      end
      ST_CNT_HI: begin
        if (i_rx_valid) begin
          if (count_full == 16'd0)                state_d = ST_FINISH;
          else if ({1'b0, count_full} > CAPACITY) state_d = ST_ERROR;
          else                                    state_d = ST_DATA;
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_DATA: begin
        if (word_done && (remain_q <= 16'd1)) state_d = ST_FINISH;
        else if (timeout)                     state_d = ST_ERROR;
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      count_lo_q <= '0;
      remain_q   <= '0;
      addr_q     <= '0;
      timer_q    <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      wen_q <= 1'b0;

      if ((state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) || in_data)
        timer_q <= i_rx_valid ? '0 : timer_inc;
      else
        timer_q <= '0;

      if ((state_q == ST_CNT_LO) && i_rx_valid) count_lo_q <= i_rx_data;

      if ((state_q == ST_CNT_HI) && i_rx_valid) begin
        remain_q <= count_full;
        addr_q   <= '0;
      end

      // Capture the finished word; the write strobe appears the following cycle.
      if (in_data && word_done) begin
        wen_q   <= 1'b1;
        waddr_q <= addr_q;
        wdata_q <= word;
        addr_q  <= addr_q + IMEM_ADDR_WIDTH'(ADDR_INCR);
        if (remain_q != 16'd0) remain_q <= remain_q - 16'd1;
      end
    end
  end

  assign o_imem_wen   = wen_q;
  assign o_imem_waddr = waddr_q;
  assign o_imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [9:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        imem_wen, cpu_en, cpu_rst, busy, done, err;

  int n_checks = 0;
  int n_pass   = 0;

  int          ncyc = 0;
  int          strobe_q[$];
  int          wen_cyc_q[$];
  logic [31:0] wen_addr_q[$];
  logic [31:0] wen_data_q[$];
  int          done_n, rst_n, err_n, done_cyc, err_cyc, en_low_n;
  logic        prev_done, en_after_done;

  logic [7:0] nominal[11] = '{8'h4C, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] b2b[11]     = '{8'h4C, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                              8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] noise[6]    = '{8'h00, 8'hFF, 8'h4B, 8'h4C, 8'h00, 8'h00};
  logic [7:0] reload[7]   = '{8'h4C, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};

  imem_loader #(
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk          (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_imem_waddr (imem_waddr),
    .o_imem_wdata (imem_wdata),
    .o_imem_wen   (imem_wen),
    .o_cpu_en     (cpu_en),
    .o_cpu_rst    (cpu_rst),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) strobe_q.push_back(ncyc);
      if (imem_wen) begin
        wen_cyc_q.push_back(ncyc);
        wen_addr_q.push_back(32'(imem_waddr));
        wen_data_q.push_back(imem_wdata);
      end
      if (done) begin done_n++; done_cyc = ncyc; end
      if (cpu_rst) rst_n++;
      if (err) begin err_n++; err_cyc = ncyc; end
      if (!cpu_en) en_low_n++;
      if (prev_done) en_after_done = cpu_en;
      prev_done = done;
      ncyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [7:0] b, input logic v);
    @(posedge clk);
    #2;
    rx_data  = b;
    rx_valid = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0);
  endtask

  task automatic clear_log();
    strobe_q.delete();
    wen_cyc_q.delete();
    wen_addr_q.delete();
    wen_data_q.delete();
    done_n = 0; rst_n = 0; err_n = 0; done_cyc = -1; err_cyc = -1;
    en_low_n = 0; en_after_done = 1'b0;
  endtask

  function automatic int sq(input int i);
    return (i < strobe_q.size()) ? strobe_q[i] : -1000;
  endfunction

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; prev_done = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_cpu_en", 32'(cpu_en), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_wen", 32'(imem_wen), 0);
    check("rst_waddr", 32'(imem_waddr), 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_pulses", {29'd0, cpu_rst, done, err}, 0);
    rst = 1'b0;
    idle(2);

    // Nominal two-word load with a gap between bytes
    clear_log();
    foreach (nominal[i]) begin drive(nominal[i], 1'b1); idle(1); end
    idle(5);
    check("nom_wen_count", wen_cyc_q.size(), 2);
    if (wen_cyc_q.size() == 2) begin
      check("nom_addr0", wen_addr_q[0], 32'h0);
      check("nom_data0", wen_data_q[0], 32'h0000_0013);
      check("nom_addr1", wen_addr_q[1], 32'h4);
      check("nom_data1", wen_data_q[1], 32'h0010_0093);
      check("nom_lat0", wen_cyc_q[0], sq(6) + 1);
      check("nom_lat1", wen_cyc_q[1], sq(10) + 1);
      check("nom_done_with_wen", done_cyc, wen_cyc_q[1]);
    end
    check("nom_done_n", done_n, 1);
    check("nom_cpu_rst_n", rst_n, 1);
    check("nom_err_n", err_n, 0);
    check("nom_en_low", en_low_n, done_cyc - sq(0));
    check("nom_en_after", 32'(en_after_done), 1);

    // Noise bytes then a zero-length load
    clear_log();
    foreach (noise[i]) begin drive(noise[i], 1'b1); idle(1); end
    idle(5);
    check("zero_wen_count", wen_cyc_q.size(), 0);
    check("zero_done_n", done_n, 1);
    check("zero_cpu_rst_n", rst_n, 1);
    check("zero_done_cyc", done_cyc, sq(5) + 1);
    check("zero_en_after", 32'(en_after_done), 1);

    // Count 257 exceeds the 256-word memory
    clear_log();
    drive(8'h4C, 1'b1); drive(8'h01, 1'b1); drive(8'h01, 1'b1);
    idle(5);
    check("ovf_err_n", err_n, 1);
    check("ovf_err_cyc", err_cyc, sq(2) + 1);
    check("ovf_wen_count", wen_cyc_q.size(), 0);
    check("ovf_no_restart", rst_n + done_n, 0);
    check("ovf_cpu_en", 32'(cpu_en), 1);

    // Silence after the first data byte
    clear_log();
    drive(8'h4C, 1'b1); drive(8'h01, 1'b1); drive(8'h00, 1'b1); drive(8'hAA, 1'b1);
    idle(60);
    check("to_err_n", err_n, 1);
    check("to_err_cyc", err_cyc - sq(3), 50);
    check("to_wen_count", wen_cyc_q.size(), 0);
    check("to_done_n", done_n, 0);

    // Continuous strobes: byte 0 of word 1 lands in the wen cycle of word 0
    clear_log();
    foreach (b2b[i]) drive(b2b[i], 1'b1);
    idle(5);
    check("b2b_wen_count", wen_cyc_q.size(), 2);
    if (wen_cyc_q.size() == 2) begin
      check("b2b_data0", wen_data_q[0], 32'h4433_2211);
      check("b2b_addr0", wen_addr_q[0], 32'h0);
      check("b2b_data1", wen_data_q[1], 32'h8877_6655);
      check("b2b_addr1", wen_addr_q[1], 32'h4);
      check("b2b_overlap", wen_cyc_q[0], sq(7));
      check("b2b_lat1", wen_cyc_q[1], sq(10) + 1);
    end
    check("b2b_done_cyc", done_cyc, sq(10) + 1);

    // Asynchronous reset after two data bytes, then a fresh load
    clear_log();
    drive(8'h4C, 1'b1); drive(8'h01, 1'b1); drive(8'h00, 1'b1);
    drive(8'hAA, 1'b1); drive(8'hBB, 1'b1);
    drive(8'h00, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_cpu_en", 32'(cpu_en), 1);
    check("mid_rst_wen", 32'(imem_wen), 0);
    check("mid_rst_waddr", 32'(imem_waddr), 0);
    check("mid_rst_wdata", imem_wdata, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);
    clear_log();
    foreach (reload[i]) begin drive(reload[i], 1'b1); idle(1); end
    idle(5);
    check("reload_wen_count", wen_cyc_q.size(), 1);
    if (wen_cyc_q.size() == 1) begin
      check("reload_addr", wen_addr_q[0], 32'h0);
      check("reload_data", wen_data_q[0], 32'h1234_5678);
    end
    check("reload_done_n", done_n, 1);
    check("reload_err_n", err_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot/debug sequencer that loads a program from the UART receiver into instruction memory while the CPU pipeline is held.
- Parses a byte stream: command byte, 16-bit word count, then little-endian 32-bit words.
- Drives the instruction-memory write port and gates the PC/IF enables.
- Pulses a CPU restart when the load completes, so the PC begins at address 0.

Parameters:
- IMEM_ADDR_WIDTH, 10, instruction-memory byte-address width; capacity is 2^(IMEM_ADDR_WIDTH-2) words.
- IMEM_DATA_WIDTH, 32, word width; fixed at 4 bytes.
- CMD_LOAD, 8'h4C, command byte that starts a load ('L').
- TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes while a load is in progress.
- NB_TIMEOUT, 20, width of the timeout counter.

Ports:
- clk  input  1  system clock
- i_rst  input  1  reset; asynchronous, active-high
- i_rx_data  input  8  received UART byte
- i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in that cycle
- o_imem_waddr  output  IMEM_ADDR_WIDTH  imem byte address, word aligned
- o_imem_wdata  output  IMEM_DATA_WIDTH  imem write data
- o_imem_wen  output  1  imem write strobe, one cycle per word
- o_cpu_en  output  1  PC and IF/ID enable; 0 while loading
- o_cpu_rst  output  1  one-cycle CPU restart pulse, ORed into pipeline reset
- o_busy  output  1  load in progress
- o_done  output  1  one-cycle pulse on successful completion
- o_err  output  1  one-cycle pulse on overflow or timeout

Behaviour:
- Reset: state=IDLE and all registers cleared.
  - Output reset values: o_cpu_en=1, o_busy=0, o_imem_wen=0, o_imem_waddr=0, o_imem_wdata=0, o_cpu_rst=0, o_done=0, o_err=0.
  - Reset asserted mid-load aborts the load immediately. Nothing further is written and there is no done/err pulse.
- States: IDLE, CNT_LO, CNT_HI, DATA, FINISH, ERROR.
- o_cpu_en=1 only in IDLE. o_busy=1 in CNT_LO, CNT_HI, DATA and FINISH.
- IDLE:
  - A byte equal to CMD_LOAD moves to CNT_LO.
  - Any other byte is ignored.
- CNT_LO: the byte becomes count[7:0]; move to CNT_HI.
- CNT_HI: the byte becomes count[15:8], then:
  - count==0 -> FINISH.
  - count > 2^(IMEM_ADDR_WIDTH-2) -> ERROR.
  - Otherwise -> DATA, with byte index=0 and write address=0.
- DATA:
  - Each byte is shifted into bits [8*idx+7:8*idx] (little-endian); idx increments.
  - On the 4th byte (idx==3): register the assembled word and address, assert o_imem_wen in the next cycle, then advance the address by 4 and decrement the remaining count.
  - If that word was the last one, move to FINISH. Otherwise stay in DATA with idx=0.
- Write latency: o_imem_wen rises exactly 1 cycle after the strobe of the 4th byte. o_imem_waddr/o_imem_wdata are stable during that cycle.
- A byte strobe coincident with the o_imem_wen cycle is accepted as byte 0 of the next word and is not lost.
- FINISH:
  - Lasts one cycle: o_cpu_rst=1 and o_done=1. The last word's o_imem_wen is asserted in this same cycle.
  - Then IDLE (o_cpu_en returns to 1).
- ERROR: lasts one cycle with o_err=1, then IDLE. Words already written stay in memory. No o_cpu_rst pulse.
- Timeout:
  - The counter clears on every accepted byte and counts in CNT_LO, CNT_HI and DATA.
  - Reaching TIMEOUT_CYCLES-1 with no byte moves to ERROR.
  - A byte arriving in the same cycle as the timeout wins: the byte is accepted and the counter clears.
- Bytes arriving in FINISH or ERROR are dropped.
- Address arithmetic: modulo 2^IMEM_ADDR_WIDTH. The count check guarantees no wrap in legal loads.
- The remaining-word counter is 16 bits and never underflows.

Decomposition:
- Shared package holds:
  - State encoding (3-bit enum/localparams).
  - CMD_LOAD.
  - Bytes-per-word constant (4).
  - Word-aligned address increment (4), also used by the PC adder.
- One natural sub-module, word_assembler: byte shift register, idx counter, and "word complete" strobe.
- FSM, counters and timeout stay in imem_loader.

Test Plan:
- Reset mid-operation: assert i_rst (async, between clock edges) after 2 data bytes -> outputs at reset values immediately; a fresh 'L' load then succeeds.
- Nominal load: send 4C 02 00 13 00 00 00 93 00 10 00 -> two wen pulses: addr 0 with data 0x00000013, then addr 4 with data 0x00100093 (each 1 cycle after its 4th byte). Also required: o_cpu_en=0 throughout the load; o_cpu_rst and o_done pulse once; o_cpu_en=1 the cycle after.
- Noise and zero count: bytes 00 FF 4B before 4C 00 00 -> no writes, FINISH pulse, back to IDLE; garbage bytes are ignored.
- Overflow: 4C 01 01 (257 > 256) -> o_err pulse 1 cycle after the high count byte; no wen; o_cpu_en=1 afterwards.
- Timeout: TIMEOUT_CYCLES=50, send 4C 01 00 AA then silence -> o_err exactly 50 cycles after the AA strobe; no wen.
- Back-to-back: byte strobe in the same cycle as a wen pulse -> that byte lands in bits [7:0] of the next word; word count and addresses stay correct.
